// File: rtl/weight_rom_sequencer.sv
// weight_rom_sequencer: walks one conv layer's weight ROM region, streaming tagged words aligned to the ROM read latency.
// Define WEIGHT_SEQ_PERF_EN to build the stall_cycles performance counter.
module weight_rom_sequencer #(
  parameter int ROM_DEPTH = 2696,
  parameter int ADDR_W = $clog2(ROM_DEPTH),
  parameter int MAX_FILTERS = 64,
  parameter int MAX_CH_GROUPS = 16,
  parameter int MAX_KERNEL_ROWS = 4,
  localparam int FW = $clog2(MAX_FILTERS + 1),
  localparam int GW = $clog2(MAX_CH_GROUPS + 1),
  localparam int RW = $clog2(MAX_KERNEL_ROWS + 1),
  localparam int FI = $clog2(MAX_FILTERS),
  localparam int GI = $clog2(MAX_CH_GROUPS),
  localparam int RI = $clog2(MAX_KERNEL_ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [FW-1:0]     cfg_num_filters,
  input  logic [GW-1:0]     cfg_num_ch_groups,
  input  logic [RW-1:0]     cfg_kernel_rows,
  input  logic              weights_ready,
  output logic              rom_read_enable,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              weights_valid,
  output logic [FI-1:0]     tag_filter,
  output logic [GI-1:0]     tag_ch_group,
  output logic [RI-1:0]     tag_row,
  output logic              tag_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_error,
  output logic [31:0]       stall_cycles
);
  localparam int TW = FW + GW + RW;
  localparam int CW = (TW > ADDR_W ? TW : ADDR_W) + 1;
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, DRAIN, FINISH} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [FW-1:0] nf_q, nf_d, filt_q, filt_d, filt_inc;
  logic [GW-1:0] ng_q, ng_d, grp_q, grp_d, grp_inc;
  logic [RW-1:0] nr_q, nr_d, row_q, row_d, row_inc;
  logic [TW-1:0] cnt_q, cnt_d, prod;
  logic [CW-1:0] span;
  logic [FI-1:0] tf_q, tf_d;
  logic [GI-1:0] tg_q, tg_d;
  logic [RI-1:0] tr_q, tr_d;
  logic err_q, err_d, valid_q, valid_d, last_q, last_d;
  logic issue, bad, at_last, row_end, grp_end;
  // Config is frozen after the latch, so the product stays valid for the whole sequence.
  assign prod = TW'(nf_q) * TW'(ng_q) * TW'(nr_q);
  assign span = CW'(base_q) + CW'(prod);
  assign bad = prod == '0 || span > CW'(ROM_DEPTH);
  assign at_last = cnt_q == prod - TW'(1);
  assign issue = state_q == ISSUE && weights_ready;
  assign row_inc = row_q + RW'(1);
  assign grp_inc = grp_q + GW'(1);
  assign filt_inc = filt_q + FW'(1);
  assign row_end = row_inc == nr_q;
  assign grp_end = grp_inc == ng_q;
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    nf_d = nf_q;
    ng_d = ng_q;
    nr_d = nr_q;
    filt_d = filt_q;
    grp_d = grp_q;
    row_d = row_q;
    cnt_d = cnt_q;
    err_d = err_q;
    valid_d = issue && !abort;
    last_d = issue && !abort && at_last;
    tf_d = issue ? filt_q[FI-1:0] : tf_q;
    tg_d = issue ? grp_q[GI-1:0] : tg_q;
    tr_d = issue ? row_q[RI-1:0] : tr_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CHECK;
        base_d = cfg_base_addr;
        nf_d = cfg_num_filters;
        ng_d = cfg_num_ch_groups;
        nr_d = cfg_kernel_rows;
        filt_d = '0;
        grp_d = '0;
        row_d = '0;
        cnt_d = '0;
      end
      CHECK: begin
        state_d = bad ? FINISH : ISSUE;
        err_d = bad && prod != '0;
      end
      ISSUE: if (weights_ready) begin
        cnt_d = cnt_q + TW'(1);
        row_d = row_end ? '0 : row_inc;
        grp_d = row_end ? (grp_end ? '0 : grp_inc) : grp_q;
        filt_d = (row_end && grp_end) ? (filt_inc == nf_q ? '0 : filt_inc) : filt_q;
        state_d = at_last ? DRAIN : ISSUE;
      end
      DRAIN: state_d = FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      base_q <= '0;
      nf_q <= '0;
      ng_q <= '0;
      nr_q <= '0;
      filt_q <= '0;
      grp_q <= '0;
      row_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      tf_q <= '0;
      tg_q <= '0;
      tr_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      nf_q <= nf_d;
      ng_q <= ng_d;
      nr_q <= nr_d;
      filt_q <= filt_d;
      grp_q <= grp_d;
      row_q <= row_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      valid_q <= valid_d;
      last_q <= last_d;
      tf_q <= tf_d;
      tg_q <= tg_d;
      tr_q <= tr_d;
    end
  end
  assign rom_read_enable = issue;
  assign rom_addr = state_q == ISSUE ? base_q + ADDR_W'(cnt_q) : '0;
  assign weights_valid = valid_q;
  assign tag_filter = tf_q;
  assign tag_ch_group = tg_q;
  assign tag_row = tr_q;
  assign tag_last = last_q;
  assign busy = state_q != IDLE;
  assign done = state_q == FINISH && !abort;
  assign cfg_error = done && err_q;
`ifdef WEIGHT_SEQ_PERF_EN
  logic [31:0] stall_q, stall_d;
  always_comb stall_d = (state_q == IDLE && start) ? '0 :
                        (state_q == ISSUE && !weights_ready && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_weight_rom_sequencer.sv
// tb_weight_rom_sequencer: scoreboard bench; expected addresses and tags are queued at start and checked as the DUT emits them.
module tb_weight_rom_sequencer;
  localparam int AW = 12;
`ifdef WEIGHT_SEQ_PERF_EN
  localparam int EXP_STALL = 3;
`else
  localparam int EXP_STALL = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic weights_ready = 1'b1;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [6:0] cfg_num_filters = '0;
  logic [4:0] cfg_num_ch_groups = '0;
  logic [2:0] cfg_kernel_rows = '0;
  logic rom_read_enable, weights_valid, tag_last, busy, done, cfg_error;
  logic [AW-1:0] rom_addr;
  logic [5:0] tag_filter;
  logic [3:0] tag_ch_group;
  logic [1:0] tag_row;
  logic [31:0] stall_cycles;
  int checks = 0, errors = 0, cyc = 0;
  int rd_cnt = 0, vld_cnt = 0, done_cnt = 0, done_cyc = 0, last_rd = 0;
  logic err_at_done = 1'b0;
  int sc, r0, v0, d0;
  logic [AW-1:0] addr_q[$];
  logic [12:0] tag_q[$];

  weight_rom_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_base_addr(cfg_base_addr), .cfg_num_filters(cfg_num_filters),
    .cfg_num_ch_groups(cfg_num_ch_groups), .cfg_kernel_rows(cfg_kernel_rows),
    .weights_ready(weights_ready), .rom_read_enable(rom_read_enable), .rom_addr(rom_addr),
    .weights_valid(weights_valid), .tag_filter(tag_filter), .tag_ch_group(tag_ch_group),
    .tag_row(tag_row), .tag_last(tag_last), .busy(busy), .done(done),
    .cfg_error(cfg_error), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (!reset) begin
    if (rom_read_enable) begin
      if (addr_q.size() == 0) chk("extra_read", 1, 0);
      else chk("addr", 64'(rom_addr), 64'(addr_q.pop_front()));
      rd_cnt++;
      last_rd = cyc;
    end
    if (weights_valid) begin
      if (tag_q.size() == 0) chk("extra_valid", 1, 0);
      else chk("tag", 64'({tag_filter, tag_ch_group, tag_row, tag_last}), 64'(tag_q.pop_front()));
      vld_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      err_at_done = cfg_error;
    end
  end

  task automatic start_seq(input int base, input int f, input int g, input int r, output int s);
    int n = 0;
    int total = f * g * r;
    cfg_base_addr = AW'(base);
    cfg_num_filters = 7'(f);
    cfg_num_ch_groups = 5'(g);
    cfg_kernel_rows = 3'(r);
    if (total > 0 && base + total <= 2696)
      for (int fi = 0; fi < f; fi++)
        for (int gi = 0; gi < g; gi++)
          for (int ri = 0; ri < r; ri++) begin
            addr_q.push_back(AW'(base + n));
            tag_q.push_back({6'(fi), 4'(gi), 2'(ri), n == total - 1});
            n++;
          end
    @(posedge clk);
    #1 start = 1'b1;
    s = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    cfg_base_addr = AW'($urandom);
    cfg_num_filters = 7'($urandom);
    cfg_num_ch_groups = 5'($urandom);
    cfg_kernel_rows = 3'($urandom);
  endtask

  task automatic wait_done(input int limit);
    int d = done_cnt;
    int k = 0;
    while (done_cnt == d && k < limit) begin
      @(posedge clk);
      k++;
    end
    chk("done_seen", 64'(done_cnt != d), 1);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk("reset_outs", {rom_read_enable, rom_addr, weights_valid, tag_filter, tag_ch_group, tag_row,
                          tag_last, busy, done, cfg_error, stall_cycles}, 0);
    reset = 1'b0;
    // basic stream
    r0 = rd_cnt;
    v0 = vld_cnt;
    start_seq(100, 2, 2, 3, sc);
    @(negedge clk);
    chk("check_no_read", {rom_read_enable, rom_addr}, 0);
    @(negedge clk);
    chk("first_issue", {rom_read_enable, weights_valid}, 2'b10);
    @(negedge clk);
    chk("valid_lat", weights_valid, 1);
    wait_done(40);
    chk("done_lat", done_cyc - last_rd, 2);
    chk("burst_len", last_rd - (sc + 2), 11);
    chk("basic_err", err_at_done, 0);
    chk("basic_reads", rd_cnt - r0, 12);
    chk("basic_valids", vld_cnt - v0, 12);
    chk("basic_q", addr_q.size() + tag_q.size(), 0);
    // backpressure on ISSUE cycles 3..5
    r0 = rd_cnt;
    v0 = vld_cnt;
    start_seq(100, 2, 2, 3, sc);
    repeat (3) @(posedge clk);
    #1 weights_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 weights_ready = 1'b1;
    wait_done(40);
    chk("bp_reads", rd_cnt - r0, 12);
    chk("bp_valids", vld_cnt - v0, 12);
    chk("bp_stall", stall_cycles, EXP_STALL);
    chk("bp_q", addr_q.size() + tag_q.size(), 0);
    // range error
    r0 = rd_cnt;
    start_seq(2690, 1, 2, 4, sc);
    wait_done(20);
    chk("rng_lat", done_cyc - sc, 2);
    chk("rng_err", err_at_done, 1);
    chk("rng_reads", rd_cnt - r0, 0);
    chk("rng_stall_clr", stall_cycles, 0);
    // exact fit at the top of the ROM
    r0 = rd_cnt;
    start_seq(2688, 1, 2, 4, sc);
    wait_done(30);
    chk("fit_err", err_at_done, 0);
    chk("fit_reads", rd_cnt - r0, 8);
    // zero config
    r0 = rd_cnt;
    start_seq(5, 0, 3, 2, sc);
    wait_done(20);
    chk("zero_err", err_at_done, 0);
    chk("zero_reads", rd_cnt - r0, 0);
    // abort on the fifth issue
    r0 = rd_cnt;
    v0 = vld_cnt;
    d0 = done_cnt;
    start_seq(100, 2, 2, 3, sc);
    for (int k = 0; k < 40 && rd_cnt - r0 < 4; k++) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_novalid", weights_valid, 0);
    repeat (3) @(negedge clk);
    chk("abort_reads", rd_cnt - r0, 5);
    chk("abort_valids", vld_cnt - v0, 4);
    chk("abort_nodone", done_cnt - d0, 0);
    chk("abort_addr_left", addr_q.size(), 7);
    chk("abort_tag_left", tag_q.size(), 8);
    addr_q.delete();
    tag_q.delete();
    start_seq(100, 2, 2, 3, sc);
    wait_done(40);
    chk("restart_q", addr_q.size() + tag_q.size(), 0);
    // async reset mid-ISSUE
    start_seq(100, 2, 2, 3, sc);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("areset_outs", {rom_read_enable, rom_addr, weights_valid, tag_filter, tag_ch_group, tag_row,
                           tag_last, busy, done, cfg_error, stall_cycles}, 0);
    addr_q.delete();
    tag_q.delete();
    @(posedge clk);
    #2 reset = 1'b0;
    r0 = rd_cnt;
    repeat (5) @(posedge clk);
    #1 chk("post_reset_idle", {busy, rom_read_enable}, 0);
    chk("post_reset_reads", rd_cnt - r0, 0);
    // single-word layer
    start_seq(7, 1, 1, 1, sc);
    wait_done(20);
    chk("single_q", addr_q.size() + tag_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
